// File: rtl/data_mem_pkg.sv
// Shared types and constants for the data-memory responder.
package data_mem_pkg;
  localparam int WORD_W = 32;
  localparam int CNT_W  = 4;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    DONE
  } state_t;
endpackage

// File: rtl/mem_array.sv
// Word-organised RAM: synchronous write, registered read with a force-to-zero option.
module mem_array
  import data_mem_pkg::*;
#(
  parameter int DEPTH = 256
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     we,
  input  logic                     re,
  input  logic                     rzero,
  input  logic [$clog2(DEPTH)-1:0] addr,
  input  logic [WORD_W-1:0]        wdata,
  output logic [WORD_W-1:0]        rdata
);
  logic [WORD_W-1:0] mem [DEPTH];

  // NOTE: the storage has no reset so it maps onto RAM; only the output register is cleared.
  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
  end

  always_ff @(posedge clk) begin
    if (rst)     rdata <= '0;
    else if (re) rdata <= rzero ? '0 : mem[addr];
  end
endmodule

// File: rtl/data_mem_responder.sv
// Fixed-latency responder for the CPU data-memory port with a one-cycle ready pulse.
// Optional alignment checking is enabled with `define DATA_MEM_ALIGN_CHECK_EN.
module data_mem_responder
  import data_mem_pkg::*;
#(
  parameter int DEPTH       = 256,
  parameter int WAIT_STATES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              mem_read,
  input  logic              mem_write,
  input  logic [31:0]       addr,
  input  logic [31:0]       write_data,
  output logic [31:0]       read_data,
  output logic              ready,
  output logic              busy,
  output logic              err
);
  localparam int AW = $clog2(DEPTH);

  state_t            state, next_state;
  logic [CNT_W-1:0]  cnt;
  logic              cap_write, cap_mis;
  logic [AW-1:0]     cap_idx;
  logic [WORD_W-1:0] cap_data;

  logic              capture, in_mis;
  logic              commit, acc_write, acc_mis;
  logic [AW-1:0]     acc_idx;
  logic [WORD_W-1:0] acc_data;
  logic              unused_addr_bits;

  assign unused_addr_bits = ^{addr[31:AW+2], addr[1:0]};

`ifdef DATA_MEM_ALIGN_CHECK_EN
  assign in_mis = (addr[1:0] != 2'b00);
  assign err    = (state == DONE) && cap_mis;
`else
  assign in_mis = 1'b0;
  assign err    = 1'b0;
`endif

  assign capture = (state == IDLE) && (mem_write || mem_read);
  assign ready   = (state == DONE);
  assign busy    = (state != IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      cap_write <= 1'b0;
      cap_mis   <= 1'b0;
      cap_idx   <= '0;
      cap_data  <= '0;
    end else begin
      state <= next_state;
      if (capture) begin
        cap_write <= mem_write;
        cap_mis   <= in_mis;
        cap_idx   <= addr[AW+1:2];
        cap_data  <= write_data;
        cnt       <= CNT_W'(WAIT_STATES);
      end else if (state == WAIT) begin
        cnt <= cnt - 1'b1;
      end
    end
  end

  // NOTE: every output of this block gets a default first, so no latches are inferred.
  always_comb begin
    next_state = state;
    commit     = 1'b0;
    acc_write  = cap_write;
    acc_mis    = cap_mis;
    acc_idx    = cap_idx;
    acc_data   = cap_data;
    unique case (state)
      IDLE: if (capture) begin
        next_state = (WAIT_STATES == 0) ? DONE : WAIT;
        // With no wait states the access completes on the capture edge itself.
        if (WAIT_STATES == 0) begin
          commit    = 1'b1;
          acc_write = mem_write;
          acc_mis   = in_mis;
          acc_idx   = addr[AW+1:2];
          acc_data  = write_data;
        end
      end
      WAIT: if (cnt == CNT_W'(1)) begin
        next_state = DONE;
        commit     = 1'b1;
      end
      DONE: next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  mem_array #(.DEPTH(DEPTH)) u_mem_array (
    .clk   (clk),
    .rst   (rst),
    .we    (commit && acc_write && !acc_mis && !rst),
    .re    (commit && !acc_write && !rst),
    .rzero (acc_mis),
    .addr  (acc_idx),
    .wdata (acc_data),
    .rdata (read_data)
  );
endmodule

// File: tb/tb_data_mem_responder.sv
// Directed bench: one responder with two wait states, one with none.
module tb_data_mem_responder;
`ifdef DATA_MEM_ALIGN_CHECK_EN
  localparam bit ALIGN = 1'b1;
`else
  localparam bit ALIGN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        mem_read_v   [2];
  logic        mem_write_v  [2];
  logic [31:0] addr_v       [2];
  logic [31:0] wdata_v      [2];
  logic [31:0] read_data_v  [2];
  logic        ready_v      [2];
  logic        busy_v       [2];
  logic        err_v        [2];

  int checks = 0;
  int errors = 0;
  int busy_bad;

  always #5 clk = ~clk;

  data_mem_responder #(.DEPTH(256), .WAIT_STATES(2)) u_dut_a (
    .clk(clk), .rst(rst), .mem_read(mem_read_v[0]), .mem_write(mem_write_v[0]),
    .addr(addr_v[0]), .write_data(wdata_v[0]), .read_data(read_data_v[0]),
    .ready(ready_v[0]), .busy(busy_v[0]), .err(err_v[0])
  );

  data_mem_responder #(.DEPTH(256), .WAIT_STATES(0)) u_dut_b (
    .clk(clk), .rst(rst), .mem_read(mem_read_v[1]), .mem_write(mem_write_v[1]),
    .addr(addr_v[1]), .write_data(wdata_v[1]), .read_data(read_data_v[1]),
    .ready(ready_v[1]), .busy(busy_v[1]), .err(err_v[1])
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Called shortly after a rising edge; returns the cycle of ready (0 on timeout).
  task automatic access(input int d, input logic wr, input logic rd,
                        input logic [31:0] a, input logic [31:0] wd,
                        output int lat, output logic [31:0] rdat, output logic e);
    mem_write_v[d] = wr;
    mem_read_v[d]  = rd;
    addr_v[d]      = a;
    wdata_v[d]     = wd;
    lat      = 0;
    rdat     = 'x;
    e        = 1'bx;
    busy_bad = 0;
    @(posedge clk);
    for (int n = 1; n <= 20 && lat == 0; n++) begin
      @(negedge clk);
      if (busy_v[d] !== 1'b1) busy_bad++;
      if (ready_v[d] === 1'b1) begin
        lat  = n;
        rdat = read_data_v[d];
        e    = err_v[d];
      end
    end
    mem_write_v[d] = 1'b0;
    mem_read_v[d]  = 1'b0;
    @(posedge clk);
    #1;
    check($sformatf("busy_during d%0d a%h", d, a), busy_bad, 0);
    check($sformatf("busy_after d%0d a%h", d, a), {31'b0, busy_v[d]}, 0);
  endtask

  int          lat;
  logic [31:0] rdat;
  logic        e;
  int          saw_ready;

  initial begin
    rst = 1'b1;
    for (int d = 0; d < 2; d++) begin
      mem_read_v[d] = 1'b0; mem_write_v[d] = 1'b0; addr_v[d] = '0; wdata_v[d] = '0;
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_ready", {31'b0, ready_v[0]}, 0);
    check("rst_busy", {31'b0, busy_v[0]}, 0);
    check("rst_err", {31'b0, err_v[0]}, 0);
    check("rst_rdata", read_data_v[0], 32'h0);
    check("rst_busy_b", {31'b0, busy_v[1]}, 0);
    @(posedge clk);
    #1 rst = 1'b0;

    // Write then read 0x10 with two wait states
    access(0, 1'b1, 1'b0, 32'h10, 32'hDEADBEEF, lat, rdat, e);
    check("wr10_lat", lat, 3);
    check("wr10_err", {31'b0, e}, 0);
    access(0, 1'b0, 1'b1, 32'h10, 32'h0, lat, rdat, e);
    check("rd10_lat", lat, 3);
    check("rd10_data", rdat, 32'hDEADBEEF);
    repeat (2) @(posedge clk);
    #1 check("rd10_hold", read_data_v[0], 32'hDEADBEEF);

    // Zero wait states: alternating writes and reads
    for (int i = 0; i < 3; i++) begin
      access(1, 1'b1, 1'b0, 32'(4 * i), 32'h1000 + 32'(i), lat, rdat, e);
      check($sformatf("ws0_wr_lat %0d", i), lat, 1);
      access(1, 1'b0, 1'b1, 32'(4 * i), 32'h0, lat, rdat, e);
      check($sformatf("ws0_rd_lat %0d", i), lat, 1);
      check($sformatf("ws0_rd_data %0d", i), rdat, 32'h1000 + 32'(i));
    end
    access(1, 1'b1, 1'b0, 32'h40, 32'h5555AAAA, lat, rdat, e);
    check("ws0_hold_after_wr", read_data_v[1], 32'h1002);
    access(1, 1'b0, 1'b1, 32'h0, 32'h0, lat, rdat, e);
    check("ws0_reread0", rdat, 32'h1000);

    // Both requests high: write wins, read dropped
    access(0, 1'b1, 1'b1, 32'h20, 32'h12345678, lat, rdat, e);
    check("both_lat", lat, 3);
    check("both_no_read", read_data_v[0], 32'hDEADBEEF);
    access(0, 1'b0, 1'b1, 32'h20, 32'h0, lat, rdat, e);
    check("both_readback", rdat, 32'h12345678);

    // Address wrap at 4*DEPTH bytes
    access(0, 1'b1, 1'b0, 32'h404, 32'hA5A5A5A5, lat, rdat, e);
    access(0, 1'b0, 1'b1, 32'h004, 32'h0, lat, rdat, e);
    check("wrap_read", rdat, 32'hA5A5A5A5);

    // Reset during WAIT aborts a write
    access(0, 1'b1, 1'b0, 32'h30, 32'hCAFEF00D, lat, rdat, e);
    mem_write_v[0] = 1'b1; addr_v[0] = 32'h30; wdata_v[0] = 32'h1;
    @(posedge clk);
    #1 begin rst = 1'b1; mem_write_v[0] = 1'b0; end
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("abort_busy", {31'b0, busy_v[0]}, 0);
    check("abort_rdata", read_data_v[0], 32'h0);
    saw_ready = (ready_v[0] === 1'b1) ? 1 : 0;
    repeat (5) begin
      @(negedge clk);
      if (ready_v[0] === 1'b1) saw_ready++;
    end
    check("abort_no_ready", saw_ready, 0);
    @(posedge clk);
    #1;
    access(0, 1'b0, 1'b1, 32'h30, 32'h0, lat, rdat, e);
    check("abort_old_value", rdat, 32'hCAFEF00D);

    // Misaligned write and read
    access(0, 1'b1, 1'b0, 32'h32, 32'h77777777, lat, rdat, e);
    check("mis_wr_lat", lat, 3);
    check("mis_wr_err", {31'b0, e}, {31'b0, ALIGN});
    access(0, 1'b0, 1'b1, 32'h30, 32'h0, lat, rdat, e);
    check("mis_word30", rdat, ALIGN ? 32'hCAFEF00D : 32'h77777777);
    check("aligned_err", {31'b0, e}, 0);
    access(0, 1'b0, 1'b1, 32'h32, 32'h0, lat, rdat, e);
    check("mis_rd_data", rdat, ALIGN ? 32'h0 : 32'h77777777);
    check("mis_rd_err", {31'b0, e}, {31'b0, ALIGN});

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
